// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with per-frame BCD snapshot,
// dead-time between digits and leading-zero blanking. Define BLINK_EN for per-digit blinking.
module seg_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int DWELL_CYC    = 50000,
  parameter int DEAD_CYC     = 500,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lzb_en,
  input  logic [4*N_DIGITS-1:0] digits_bcd,
`ifdef BLINK_EN
  input  logic [N_DIGITS-1:0]   blink_mask,
`endif
  output logic [3:0]            digit_code,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_start
);

  localparam int CW = $clog2(DWELL_CYC + 1);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] DEAD_C   = CW'(DEAD_CYC);
  localparam logic [CW-1:0] DWELL_C  = CW'(DWELL_CYC);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [CW-1:0]         cnt_reg, cnt_next, cnt_inc;
  logic [4*N_DIGITS-1:0] snap_reg, snap_next;
  logic                  frame_restart, frame_wrap, frame_load;
  logic [N_DIGITS-1:0]   an_next;
  logic [3:0]            code_next;
  logic [3:0]            code_arr [N_DIGITS];
  logic [N_DIGITS-1:0]   blink_off;

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    cnt_inc       = cnt_reg + CW'(1);
    cnt_next      = cnt_reg;
    frame_restart = 1'b0;
    frame_wrap    = 1'b0;
    if (!en) begin
      state_next = S_IDLE;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next    = S_BLANK;
          idx_next      = '0;
          cnt_next      = '0;
          frame_restart = 1'b1;
        end
        S_BLANK: begin
          cnt_next = cnt_inc;
          if (cnt_inc == DEAD_C) state_next = S_ON;
        end
        S_ON: begin
          if (cnt_inc == DWELL_C) begin
            state_next = S_BLANK;
            cnt_next   = '0;
            if (idx_reg == LAST_IDX) begin
              idx_next   = '0;
              frame_wrap = 1'b1;
            end else begin
              idx_next = idx_reg + IW'(1);
            end
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = S_IDLE;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
    frame_load = frame_restart | frame_wrap;
    snap_next  = frame_load ? digits_bcd : snap_reg;
  end

`ifdef BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] BLINK_C = FW'(BLINK_FRAMES);

  logic [FW-1:0]       fcnt_reg, fcnt_next;
  logic                phase_reg, phase_next;
  logic [N_DIGITS-1:0] mask_reg, mask_next;

  // Blink cadence restarts from a known phase whenever the display is re-enabled.
  always_comb begin
    fcnt_next  = fcnt_reg;
    phase_next = phase_reg;
    mask_next  = frame_load ? blink_mask : mask_reg;
    if (!en) begin
      fcnt_next  = fcnt_reg;
    end else if (frame_restart) begin
      fcnt_next  = '0;
      phase_next = 1'b0;
    end else if (frame_wrap) begin
      if (fcnt_reg + FW'(1) == BLINK_C) begin
        fcnt_next  = '0;
        phase_next = ~phase_reg;
      end else begin
        fcnt_next = fcnt_reg + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_reg  <= '0;
      phase_reg <= 1'b0;
      mask_reg  <= '0;
    end else begin
      fcnt_reg  <= fcnt_next;
      phase_reg <= phase_next;
      mask_reg  <= mask_next;
    end
  end

  assign blink_off = phase_next ? mask_next : '0;
`else
  assign blink_off = '0;
`endif

  // Codes come from the next snapshot so the first BLANK cycle of a frame already shows fresh data.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_code
      logic [3:0] digit;
      logic       lead_zero;
      assign digit = snap_next[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign lead_zero = 1'b0;
      end else begin : g_upper
        assign lead_zero = lzb_en && (snap_next[4*N_DIGITS-1:4*gi] == '0);
      end
      assign code_arr[gi] = (lead_zero || blink_off[gi]) ? 4'hF : digit;
    end
  endgenerate

  always_comb begin
    an_next   = '1;
    code_next = 4'hF;
    if (state_next == S_ON) an_next = ~(N_DIGITS'(1) << idx_next);
    if (state_next != S_IDLE) code_next = code_arr[idx_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      snap_reg    <= '1;
      an_n        <= '1;
      digit_code  <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      snap_reg    <= snap_next;
      an_n        <= an_next;
      digit_code  <= code_next;
      frame_start <= frame_load;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the clock's multi-digit seven-segment display. It latches a BCD snapshot of all digits once per frame and steps through the digits one at a time. For each digit it drives one 4-bit code into the shared seven-segment encoder and asserts the matching active-low digit anode. A dead-time window between digits prevents ghosting, and optional leading-zero blanking suppresses unwanted zeros.

Parameters:
N_DIGITS, 4, number of scanned digits (≥2); digit 0 is rightmost, at digits_bcd[3:0].
DWELL_CYC, 50000, clock cycles per digit slot, dead time included (1 ms at 50 MHz).
DEAD_CYC, 500, cycles at the start of each slot with all anodes off; 1 ≤ DEAD_CYC < DWELL_CYC.
BLINK_FRAMES, 250, frames per blink half-period; used only with BLINK_EN.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
en  in  1  scan enable; 0 blanks the display.
lzb_en  in  1  leading-zero blanking enable.
digits_bcd  in  4*N_DIGITS  BCD digits, 4 bits each.
blink_mask  in  N_DIGITS  per-digit blink select; present only with BLINK_EN.
digit_code  out  4  code to the encoder; 4'hF = blank.
an_n  out  N_DIGITS  digit anodes, active-low.
frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- One clock, clk. Reset is synchronous and active-high: rst sampled high at a clk edge takes effect at that edge.
- Reset values: an_n all ones, digit_code 4'hF, frame_start 0, idx 0, slot counter 0, snapshot all 4'hF, blink phase 0.
- Reset mid-operation returns every output to its reset value at the next edge; the scan restarts from idx 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE: entered while en=0. an_n all ones, digit_code 4'hF.
  - BLANK: lasts DEAD_CYC cycles. an_n all ones; digit_code already shows code(idx).
  - ON: lasts DWELL_CYC-DEAD_CYC cycles. an_n[idx]=0, all other anode bits 1; digit_code holds code(idx).
- Transitions:
  - IDLE→BLANK with idx=0 when en=1.
  - BLANK→ON when the slot counter reaches DEAD_CYC.
  - ON→BLANK when the slot counter reaches DWELL_CYC; idx increments modulo N_DIGITS and the counter clears.
  - Any state→IDLE on the first edge with en=0; outputs are blanked at that same edge.
- Frame period is N_DIGITS*DWELL_CYC cycles.
- Snapshot and frame_start:
  - On every entry to BLANK with idx=0 (including from IDLE), the snapshot loads digits_bcd and frame_start pulses for one cycle.
  - Input changes mid-frame are not shown until the next frame.
- code(k):
  - Base value is snapshot digit k.
  - Values 10–15 pass through unchanged; the encoder shows them blank.
  - With lzb_en=1, digit k is forced to 4'hF if k>0 and every snapshot digit from N_DIGITS-1 down to k equals 0. Digit 0 is never blanked, so all-zero input shows a single "0".
- The slot and blink counters are sized by clog2 of their limits; wrap-around is explicit.

Optional Feature:
BLINK_EN
- Defined:
  - Adds the blink_mask port and a frame counter. The blink phase toggles each time BLINK_FRAMES frames complete.
  - While phase=1, any digit whose blink_mask bit was set in the frame snapshot outputs code 4'hF. Its anode still scans, so timing is unchanged.
  - The mask is captured into the snapshot alongside digits_bcd.
  - The counter and phase reset to 0 on rst and on the IDLE→BLANK transition.
- Not defined: no blink_mask port, no counter logic, and code() ignores blinking.

Test Plan:
All directed tests use N_DIGITS=4, DWELL_CYC=8, DEAD_CYC=2, BLINK_FRAMES=2.
1. Reset: hold rst=1 for 3 cycles with en=1 → an_n=4'b1111, digit_code=4'hF, frame_start=0 every cycle; after release, the first frame_start pulse occurs on the first edge.
2. Basic scan: en=1, digits_bcd=16'h1234, lzb_en=0 → per slot, 2 cycles with an_n=1111 then 6 cycles with an_n=1110 (digit_code=4), then 1101/3, 1011/2, 0111/1; frame_start repeats every 32 cycles.
3. Leading-zero blanking: digits=16'h0007, lzb_en=1 → codes 7,F,F,F for idx 0..3. With digits=16'h0000: 0,F,F,F. With digits=16'h0207: 7,0,2,F.
4. Snapshot: change digits from 16'h1234 to 16'h5678 during slot 1 → rest of frame shows 3,2,1; next frame shows 8,7,6,5.
5. Enable drop and reset mid-slot: drop en during an ON cycle → next edge an_n=1111, code F. Re-assert en → frame_start pulses, scan restarts at idx 0. Asserting rst mid-slot gives the same outcome.
6. BLINK_EN: blink_mask=4'b0001, digits=16'h1234 → frames 0–1 show digit 0 = 4, frames 2–3 show F, frames 4–5 show 4. Anode pattern is identical in all frames.
